// File: rtl/ssf_sample_feeder.sv
// ---------------------------------------------------------------------------
// ssf_sample_feeder
//   Upstream input stage for ssfblackbox. Signed samples from the acquisition
//   side are buffered in a DEPTH-entry FIFO. One sample is held in a head
//   register (out_data) and is replaced only when the consumer asks for the
//   next one with req == 2'd1. Overrun and underrun events are reported on
//   sticky flags.
//
//   Handshake: the producer's sample is accepted on a rising edge where
//   in_valid && in_ready. in_ready depends only on the registered level, so a
//   pop in the same cycle never makes room for the write. A write attempted
//   while in_ready == 0 is dropped and sets overrun.
//
// Ports
//   clk        single clock, all state on posedge
//   rst        asynchronous, active-high reset
//   in_valid   producer has a sample on in_data
//   in_data    signed sample from producer
//   in_ready   FIFO not full (from registered level)
//   req        consumer request, 2'd1 = advance, other codes ignored
//   out_data   registered head sample presented to the consumer
//   out_valid  out_data holds a sample not yet consumed by an underrun
//   level      FIFO occupancy 0..DEPTH, head register not included
//   overrun    sticky: write attempted while full
//   underrun   sticky: advance requested with nothing to pop
//   clr_flags  synchronous clear of both flags (a same-cycle event wins)
//
// Configuration macro
//   SSF_FEED_ZERO_FILL_EN  defined: out_data is zeroed on underrun;
//                          undefined: out_data keeps its last value.
// ---------------------------------------------------------------------------
module ssf_sample_feeder #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [1:0]    req,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          underrun,
  input  logic          clr_flags
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_LVL = '0;
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);
  localparam logic [1:0]  REQ_ADV  = 2'd1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;

  logic full, empty, wr_en, pop, prime, advance, ovr_evt, und_evt;

  // All decisions below look only at pre-edge registered state; there is no
  // bypass from in_data to out_data.
  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == ZERO_LVL);
  assign wr_en   = in_valid && !full;
  assign ovr_evt = in_valid && full;
  // Prime fills an empty head register without waiting for a request.
  assign prime   = !out_valid_q && !empty;
  assign advance = (req == REQ_ADV) && out_valid_q && !empty;
  assign pop     = prime || advance;
  assign und_evt = (req == REQ_ADV) && empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end else if (und_evt) begin
      out_valid_d = 1'b0;
`ifdef SSF_FEED_ZERO_FILL_EN
      out_data_d  = '0;
`else
      out_data_d  = out_data_q;
`endif
    end

    case ({wr_en, pop})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase

    // Clear first, then OR in this cycle's event so a new event wins.
    overrun_d  = (overrun_q  && !clr_flags) || ovr_evt;
    underrun_d = (underrun_q && !clr_flags) || und_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready  = !full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

endmodule
